// File: rtl/fp_multiplier_arbiter.sv
// Round-robin arbiter that time-shares one combinational FP multiplier among
// NUM_REQUESTERS valid/ready clients and returns a single tagged response stream.

module floating_point_multiplier #(
    parameter int unsigned EXPONENT_WIDTH = 8,
    parameter int unsigned MANTISSA_WIDTH = 23
) (
    input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] a_i,
    input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] b_i,
    output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] p_o,
    output logic [2:0]                             flags_o
);
    localparam int unsigned E    = EXPONENT_WIDTH;
    localparam int unsigned M    = MANTISSA_WIDTH;
    localparam int unsigned MW1  = M + 1;
    localparam int unsigned PW   = 2 * (M + 1);
    localparam int unsigned XW   = E + 2;
    localparam int unsigned BIAS = (1 << (E - 1)) - 1;
    localparam int unsigned EMAX = (1 << E) - 1;

    logic              sa, sb, sp;
    logic [E-1:0]      ea, eb;
    logic [M-1:0]      fa, fb;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [PW-1:0]     prod;
    logic [PW-2:0]     norm;
    logic [M-1:0]      frac_t;
    logic              guard, sticky, rnd_up;
    logic [M:0]        frac_r;
    logic signed [XW-1:0] exp_n, exp_r;

    assign {sa, ea, fa} = a_i;
    assign {sb, eb, fb} = b_i;
    assign sp = sa ^ sb;

    // Subnormal operands are treated as zero; tiny results flush to signed zero.
    assign a_nan  = (ea == {E{1'b1}}) && (fa != '0);
    assign b_nan  = (eb == {E{1'b1}}) && (fb != '0);
    assign a_inf  = (ea == {E{1'b1}}) && (fa == '0);
    assign b_inf  = (eb == {E{1'b1}}) && (fb == '0);
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);

    always_comb begin
        prod   = PW'({1'b1, fa}) * PW'({1'b1, fb});
        norm   = prod[PW-1] ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
        frac_t = norm[PW-2 -: M];
        guard  = norm[PW-2-M];
        sticky = |norm[PW-3-M:0];
        rnd_up = guard & (sticky | frac_t[0]);
        frac_r = {1'b0, frac_t} + MW1'(rnd_up);
        exp_n  = $signed(XW'(ea)) + $signed(XW'(eb)) - $signed(XW'(BIAS))
               + $signed(XW'(prod[PW-1]));
        exp_r  = exp_n + $signed(XW'(frac_r[M]));

        p_o     = {sp, exp_r[E-1:0], frac_r[M-1:0]};
        flags_o = 3'b000;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            p_o     = {1'b1, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
            flags_o = 3'b100;
        end else if (a_inf || b_inf) begin
            p_o = {sp, {E{1'b1}}, {M{1'b0}}};
        end else if (a_zero || b_zero) begin
            p_o = {sp, {(E+M){1'b0}}};
        end else if (exp_r >= $signed(XW'(EMAX))) begin
            p_o     = {sp, {E{1'b1}}, {M{1'b0}}};
            flags_o = 3'b010;
        end else if (exp_r < $signed(XW'(1))) begin
            p_o     = {sp, {(E+M){1'b0}}};
            flags_o = 3'b001;
        end
    end
endmodule

module fp_multiplier_arbiter #(
    parameter int unsigned EXPONENT_WIDTH = 8,
    parameter int unsigned MANTISSA_WIDTH = 23,
    parameter int unsigned NUM_REQUESTERS = 4
) (
    input  logic                                                  clk,
    input  logic                                                  rst_n,
    input  logic [NUM_REQUESTERS-1:0]                             req_valid_i,
    output logic [NUM_REQUESTERS-1:0]                             req_ready_o,
    input  logic [NUM_REQUESTERS*(EXPONENT_WIDTH+MANTISSA_WIDTH+1)-1:0] req_a_i,
    input  logic [NUM_REQUESTERS*(EXPONENT_WIDTH+MANTISSA_WIDTH+1)-1:0] req_b_i,
    output logic                                                  resp_valid_o,
    input  logic                                                  resp_ready_i,
    output logic [((NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1)-1:0] resp_id_o,
    output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0]                resp_out_o,
    output logic [2:0]                                            resp_flags_o,
    output logic [15:0]                                           ops_done_o
);
    localparam int unsigned W  = EXPONENT_WIDTH + MANTISSA_WIDTH + 1;
    localparam int unsigned N  = NUM_REQUESTERS;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, COMPUTE, RESPOND} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] id_q, id_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d;
    logic          valid_q, valid_d;
    logic [W-1:0]  out_q, out_d;
    logic [2:0]    flags_q, flags_d;
    logic [15:0]   ops_q, ops_d;

    logic          gnt_found_c;
    logic [IW-1:0] gnt_id_c;
    logic [W-1:0]  sel_a_c, sel_b_c;
    logic [W-1:0]  mul_p;
    logic [2:0]    mul_flags;

    floating_point_multiplier #(
        .EXPONENT_WIDTH (EXPONENT_WIDTH),
        .MANTISSA_WIDTH (MANTISSA_WIDTH)
    ) u_mul (
        .a_i     (a_q),
        .b_i     (b_q),
        .p_o     (mul_p),
        .flags_o (mul_flags)
    );

    // First requester at or after rr_ptr, wrapping modulo N.
    always_comb begin
        gnt_found_c = 1'b0;
        gnt_id_c    = '0;
        for (int k = 0; k < int'(N); k++) begin
            for (int i = 0; i < int'(N); i++) begin
                if (!gnt_found_c && req_valid_i[i]
                    && (((int'(rr_ptr_q) + k) % int'(N)) == i)) begin
                    gnt_found_c = 1'b1;
                    gnt_id_c    = IW'(i);
                end
            end
        end
    end

    always_comb begin
        sel_a_c     = '0;
        sel_b_c     = '0;
        req_ready_o = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (gnt_id_c == IW'(i)) begin
                sel_a_c = req_a_i[i*W +: W];
                sel_b_c = req_b_i[i*W +: W];
                req_ready_o[i] = (state_q == IDLE) && gnt_found_c;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        a_d      = a_q;
        b_d      = b_q;
        valid_d  = valid_q;
        out_d    = out_q;
        flags_d  = flags_q;
        ops_d    = ops_q;
        case (state_q)
            IDLE: begin
                if (gnt_found_c) begin
                    a_d     = sel_a_c;
                    b_d     = sel_b_c;
                    id_d    = gnt_id_c;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                out_d   = mul_p;
                flags_d = mul_flags;
                valid_d = 1'b1;
                state_d = RESPOND;
            end
            RESPOND: begin
                if (resp_ready_i) begin
                    valid_d  = 1'b0;
                    ops_d    = ops_q + 16'd1;
                    rr_ptr_d = (id_q == IW'(N - 1)) ? '0 : id_q + IW'(1);
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            valid_q  <= 1'b0;
            out_q    <= '0;
            flags_q  <= '0;
            ops_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            a_q      <= a_d;
            b_q      <= b_d;
            valid_q  <= valid_d;
            out_q    <= out_d;
            flags_q  <= flags_d;
            ops_q    <= ops_d;
        end
    end

    assign resp_valid_o = valid_q;
    assign resp_id_o    = id_q;
    assign resp_out_o   = out_q;
    assign resp_flags_o = flags_q;
    assign ops_done_o   = ops_q;
endmodule

// File: tb/tb_fp_multiplier_arbiter.sv
// Scoreboard bench for fp_multiplier_arbiter: a driver pushes expected responses,
// a negedge monitor pops and compares on every response handshake.

module tb_fp_multiplier_arbiter;
    localparam int unsigned N  = 4;
    localparam int unsigned W  = 32;
    localparam int unsigned IW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*W-1:0]  req_a, req_b;
    logic            resp_valid, resp_ready;
    logic [IW-1:0]   resp_id;
    logic [W-1:0]    resp_out;
    logic [2:0]      resp_flags;
    logic [15:0]     ops_done;

    always #5 clk = ~clk;

    fp_multiplier_arbiter #(
        .EXPONENT_WIDTH (8),
        .MANTISSA_WIDTH (23),
        .NUM_REQUESTERS (N)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_id_o    (resp_id),
        .resp_out_o   (resp_out),
        .resp_flags_o (resp_flags),
        .ops_done_o   (ops_done)
    );

    typedef struct packed {
        logic [IW-1:0] id;
        logic [W-1:0]  out;
        logic [2:0]    flags;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          ops_model = 0;
    int          cyc = 0;
    logic [N-1:0]  s_rdy;
    logic          s_valid;
    logic [W-1:0]  s_out;
    logic [15:0]   s_ops;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, need 0x%08h", nm, act, expv);
        end
    endtask

    // Sample outputs at negedge, then drop the valid of whichever client was granted.
    task automatic tick();
        @(negedge clk);
        s_rdy   = req_ready;
        s_valid = resp_valid;
        s_out   = resp_out;
        s_ops   = ops_done;
        @(posedge clk);
        #1;
        cyc++;
        req_valid = req_valid & ~s_rdy;
    endtask

    task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] p, input logic [2:0] f, input bit push);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_valid[i]    = 1'b1;
        if (push) exp_q.push_back(exp_t'{id: IW'(i), out: p, flags: f});
    endtask

    task automatic drain(input int budget);
        int t = 0;
        while ((exp_q.size() != 0 || req_valid != '0) && t < budget) begin
            tick();
            t++;
        end
        if (exp_q.size() != 0 || req_valid != '0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d responses outstanding, req_valid=%b", exp_q.size(), req_valid);
            exp_q.delete();
            req_valid = '0;
        end
    endtask

    task automatic do_reset();
        req_valid  = '0;
        resp_ready = 1'b1;
        rst_n      = 1'b0;
        #1;
        chk("rst_valid", 32'(resp_valid), 32'h0);
        chk("rst_out",   resp_out,        32'h0);
        chk("rst_id",    32'(resp_id),    32'h0);
        chk("rst_flags", 32'(resp_flags), 32'h0);
        chk("rst_ops",   32'(ops_done),   32'h0);
        chk("rst_ready", 32'(req_ready),  32'h0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            ops_model = 0;
        end else begin
            if (resp_valid) chk("ready_in_respond", 32'(req_ready), 32'h0);
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_resp: id=%0d out=0x%08h", resp_id, resp_out);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("resp_id",    32'(resp_id),    32'(e.id));
                    chk("resp_out",   resp_out,        e.out);
                    chk("resp_flags", 32'(resp_flags), 32'(e.flags));
                    chk("ops_done",   32'(ops_done),   32'(ops_model));
                    ops_model = (ops_model + 1) % 65536;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int grants;
        int issued;
        int t;
        int gcyc[3];

        rst_n      = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;
        #2;
        do_reset();

        // Single op latency: ready in cycle 0, resp_valid in cycle 2
        issue(0, 32'h40400000, 32'h40800000, 32'h41400000, 3'b000, 1'b1);
        tick(); chk("t1_ready_c0", 32'(s_rdy), 32'h1);
        tick(); chk("t1_valid_c1", 32'(s_valid), 32'h0);
        tick(); chk("t1_valid_c2", 32'(s_valid), 32'h1);
        chk("t1_out_c2", s_out, 32'h41400000);
        tick(); chk("t1_ops", 32'(s_ops), 32'h1);

        // All four at once, round-robin from 0
        do_reset();
        issue(0, 32'h40000000, 32'h40400000, 32'h40C00000, 3'b000, 1'b1);
        issue(1, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000, 1'b1);
        issue(2, 32'hC0000000, 32'h3F000000, 32'hBF800000, 3'b000, 1'b1);
        issue(3, 32'h7F800000, 32'h40000000, 32'h7F800000, 3'b000, 1'b1);
        drain(40);
        tick(); chk("t2_ops", 32'(s_ops), 32'h4);

        // Backpressure: outputs hold, no second grant
        resp_ready = 1'b0;
        issue(0, 32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b010, 1'b1);
        issue(1, 32'h00800000, 32'h00800000, 32'h00000000, 3'b001, 1'b1);
        tick(); chk("t3_grant0", 32'(s_rdy), 32'h1);
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t3_hold_valid", 32'(s_valid), 32'h1);
            chk("t3_hold_out",   s_out,        32'h7F800000);
            chk("t3_hold_ready", 32'(s_rdy),   32'h0);
        end
        resp_ready = 1'b1;
        drain(40);

        // NaN / Inf*0 / signed zero; pointer sits at 2 so order is 2,3,0
        issue(2, 32'hFFA00000, 32'h40800000, 32'hFFC00000, 3'b100, 1'b1);
        issue(3, 32'h7F800000, 32'h00000000, 32'hFFC00000, 3'b100, 1'b1);
        issue(0, 32'h80000000, 32'h40000000, 32'h80000000, 3'b000, 1'b1);
        drain(40);

        // Reset during COMPUTE drops the op and restarts the pointer at 0
        issue(1, 32'h40000000, 32'h40000000, 32'h0, 3'b000, 1'b0);
        tick(); chk("t5_grant1", 32'(s_rdy), 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_valid_rst", 32'(resp_valid), 32'h0);
        chk("t5_ops_rst",   32'(ops_done),   32'h0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t5_no_resp", 32'(s_valid), 32'h0);
        end
        issue(0, 32'h40000000, 32'h40000000, 32'h40800000, 3'b000, 1'b1);
        issue(1, 32'h3F800000, 32'h40400000, 32'h40400000, 3'b000, 1'b1);
        drain(40);

        // Client 1 alone, three back-to-back ops with rounding
        grants = 0;
        issued = 1;
        t      = 0;
        issue(1, 32'h3FC00001, 32'h3FC00001, 32'h40100002, 3'b000, 1'b1);
        while (grants < 3 && t < 60) begin
            tick();
            t++;
            if (s_rdy[1]) begin
                gcyc[grants] = cyc;
                grants++;
                if (issued < 3) begin
                    issue(1, 32'h3FC00001, 32'h3FC00001, 32'h40100002, 3'b000, 1'b1);
                    issued++;
                end
            end
        end
        chk("t6_grants", 32'(grants), 32'd3);
        if (grants == 3) begin
            chk("t6_gap01", 32'(gcyc[1] - gcyc[0]), 32'd3);
            chk("t6_gap12", 32'(gcyc[2] - gcyc[1]), 32'd3);
        end
        drain(40);

        // Pointer now at 2: expect order 2,0,1
        issue(2, 32'h3F800000, 32'h3F800000, 32'h3F800000, 3'b000, 1'b1);
        issue(0, 32'h40000000, 32'h40000000, 32'h40800000, 3'b000, 1'b1);
        issue(1, 32'hBF800000, 32'hBF800000, 32'h3F800000, 3'b000, 1'b1);
        drain(40);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
